captura_jogada: RTL and testbench

CAPTURA_JOGADA -- requirements
Module: captura_jogada

---
 rtl/captura_jogada.sv | 183 ++++++++++++++++++
 tb/tb_captura_jogada.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/captura_jogada.sv
// captura_jogada: synchronizes and debounces the 4 player switches, then
// classifies each accepted value as a valid (one-hot) or invalid move.
// Optional feature macro: CAPTURA_JOGADA_TIMEOUT_EN. When it is defined,
// a cycle counter limits how long the block may sit armed without a move.
// db_estado exposes the FSM encoding for the 7-segment debug display.
module captura_jogada #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [3:0] chaves,
  output logic [3:0] jogada,
  output logic       jogada_feita,
  output logic       jogada_invalida,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    SOLTAR   = 4'd1,
    ARMADO   = 4'd2,
    FILTRO   = 4'd3,
    EMITE    = 4'd4,
    ESGOTADO = 4'd5
  } estado_t;

  estado_t         state_reg, state_next;
  logic [3:0]      sync_meta_reg;
  logic [3:0]      sinc_reg;
  logic [3:0]      cand_reg, cand_next;
  logic [3:0]      jogada_reg, jogada_next;
  logic [DW-1:0]   db_cnt_reg, db_cnt_next;
  logic [DW-1:0]   db_cnt_inc;
  logic            to_expired;
  logic            cand_onehot;

  // Saturating step of the debounce counter.
  assign db_cnt_inc = (db_cnt_reg == DB_MAX) ? db_cnt_reg : db_cnt_reg + DW'(1);

`ifdef CAPTURA_JOGADA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] to_cnt_reg, to_cnt_next;

  assign to_expired = (to_cnt_reg == TO_LAST);

  // Armed-time counter: counts ARMADO/FILTRO cycles, clears when leaving the armed phase.
  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (state_next == OCIOSO || state_next == SOLTAR || state_next == EMITE) begin
      to_cnt_next = '0;
    end else if ((state_reg == ARMADO || state_reg == FILTRO) && to_cnt_reg != TO_MAX) begin
      to_cnt_next = to_cnt_reg + TW'(1);
    end
  end

  // Armed-time counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_reg <= '0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end

  assign timeout = (state_reg == ESGOTADO);
`else
  // No armed-time limit in this build: ESGOTADO can never be entered.
  localparam bit TIMEOUT_PARAM_OK = (TIMEOUT_CYCLES > 0);
  assign to_expired = 1'b0;
  assign timeout    = 1'b0 & TIMEOUT_PARAM_OK;
`endif

  // Two-flop synchronizer for the asynchronous switches.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_meta_reg <= 4'b0000;
      sinc_reg      <= 4'b0000;
    end else begin
      sync_meta_reg <= chaves;
      sinc_reg      <= sync_meta_reg;
    end
  end

  // Next-state logic: release wait, arming, debounce filter and emission.
  always_comb begin
    state_next  = state_reg;
    cand_next   = cand_reg;
    jogada_next = jogada_reg;
    db_cnt_next = db_cnt_reg;
    if (!habilita) begin
      state_next  = OCIOSO;
      db_cnt_next = '0;
    end else begin
      case (state_reg)
        OCIOSO: begin
          state_next  = SOLTAR;
          db_cnt_next = '0;
        end
        SOLTAR: begin
          // Switches must read all-zero for a full debounce window.
          if (sinc_reg != 4'b0000) begin
            db_cnt_next = '0;
          end else if (db_cnt_reg == DB_LAST) begin
            state_next  = ARMADO;
            db_cnt_next = '0;
          end else begin
            db_cnt_next = db_cnt_inc;
          end
        end
        ARMADO: begin
          if (to_expired) begin
            state_next = ESGOTADO;
          end else if (sinc_reg != 4'b0000) begin
            state_next  = FILTRO;
            cand_next   = sinc_reg;
            db_cnt_next = '0;
          end
        end
        FILTRO: begin
          // Debounce completion takes priority over an expiring timeout.
          if (sinc_reg == cand_reg && db_cnt_reg == DB_LAST) begin
            state_next  = EMITE;
            jogada_next = cand_reg;
            db_cnt_next = '0;
          end else if (to_expired) begin
            state_next = ESGOTADO;
          end else if (sinc_reg == 4'b0000) begin
            state_next  = ARMADO;
            db_cnt_next = '0;
          end else if (sinc_reg != cand_reg) begin
            cand_next   = sinc_reg;
            db_cnt_next = '0;
          end else begin
            db_cnt_next = db_cnt_inc;
          end
        end
        EMITE: begin
          state_next  = SOLTAR;
          db_cnt_next = '0;
        end
        ESGOTADO: begin
          state_next = ESGOTADO;
        end
        default: begin
          state_next  = OCIOSO;
          db_cnt_next = '0;
        end
      endcase
    end
  end

  // FSM, candidate, accepted move and debounce counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= OCIOSO;
      cand_reg   <= 4'b0000;
      jogada_reg <= 4'b0000;
      db_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cand_reg   <= cand_next;
      jogada_reg <= jogada_next;
      db_cnt_reg <= db_cnt_next;
    end
  end

  assign cand_onehot     = (cand_reg != 4'b0000) && ((cand_reg & (cand_reg - 4'd1)) == 4'b0000);
  assign jogada_feita    = (state_reg == EMITE) && cand_onehot;
  assign jogada_invalida = (state_reg == EMITE) && !cand_onehot;
  assign jogada          = jogada_reg;
  assign db_estado       = state_reg;

endmodule

// File: tb/tb_captura_jogada.sv
// Randomized self-checking bench for captura_jogada with a behavioural
// reference model, plus directed scenarios for latency, invalid moves,
// timeout and asynchronous reset. Timeout expectations follow
// CAPTURA_JOGADA_TIMEOUT_EN as seen by this bench.
module tb_captura_jogada;

  localparam int D = 4;
  localparam int T = 20;
`ifdef CAPTURA_JOGADA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Phase numbers are the externally visible db_estado values.
  localparam int P_IDLE = 0, P_RELEASE = 1, P_ARMED = 2, P_FILTER = 3, P_EMIT = 4, P_EXPIRED = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilita = 1'b0;
  logic [3:0] chaves = 4'b0000;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       jogada_invalida;
  logic       timeout;
  logic [3:0] db_estado;

  always #5 clock = ~clock;

  captura_jogada #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .chaves         (chaves),
    .jogada         (jogada),
    .jogada_feita   (jogada_feita),
    .jogada_invalida(jogada_invalida),
    .timeout        (timeout),
    .db_estado      (db_estado)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_feita = 0;
  int n_inval = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         ph;
  logic [3:0] m_pipe [2];   // m_pipe[1] is the value the control decisions see
  logic [3:0] m_cand;
  logic [3:0] m_jog;
  int         m_run;        // consecutive qualifying samples in the current phase
  int         m_armed;      // cycles spent armed since the last release

  function automatic bit is_onehot(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction

  task model_reset();
    ph = P_IDLE;
    m_pipe[0] = 4'b0000;
    m_pipe[1] = 4'b0000;
    m_cand = 4'b0000;
    m_jog = 4'b0000;
    m_run = 0;
    m_armed = 0;
  endtask

  task model_edge();
    logic [3:0] s;
    bit expire;
    s = m_pipe[1];
    if (!habilita) begin
      ph = P_IDLE;
      m_run = 0;
      m_armed = 0;
    end else if (ph == P_IDLE || ph == P_EMIT) begin
      ph = P_RELEASE;
      m_run = 0;
      m_armed = 0;
    end else if (ph == P_RELEASE) begin
      m_run = (s == 0) ? m_run + 1 : 0;
      if (m_run == D) begin
        ph = P_ARMED;
        m_run = 0;
      end
    end else if (ph == P_ARMED || ph == P_FILTER) begin
      m_armed++;
      expire = TO_EN && (m_armed == T);
      if (ph == P_FILTER && s == m_cand && m_run + 1 == D) begin
        ph = P_EMIT;
        m_jog = m_cand;
        m_armed = 0;
      end else if (expire) begin
        ph = P_EXPIRED;
      end else if (s == 0) begin
        ph = P_ARMED;
        m_run = 0;
      end else if (ph == P_ARMED || s != m_cand) begin
        ph = P_FILTER;
        m_cand = s;
        m_run = 0;
      end else begin
        m_run++;
      end
    end
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = chaves;
  endtask

  task compare_all();
    check("estado", db_estado, ph);
    check("feita", jogada_feita, (ph == P_EMIT) && is_onehot(m_cand));
    check("invalida", jogada_invalida, (ph == P_EMIT) && !is_onehot(m_cand));
    check("timeout", timeout, ph == P_EXPIRED);
    if (ph != P_EMIT) check("jogada", jogada, m_jog);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task cycle(input bit h, input logic [3:0] c);
    habilita = h;
    chaves = c;
    @(posedge clock);
    if (reset) model_edge();
    #1;
    compare_all();
    n_feita += int'(jogada_feita);
    n_inval += int'(jogada_invalida);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task async_reset(input int hold);
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_jogada", jogada, 4'b0000);
    check("rst_pulses", {jogada_feita, jogada_invalida, timeout}, 3'b000);
    check("rst_estado", db_estado, P_IDLE);
    for (int i = 0; i < hold; i++) cycle(1'b1, 4'($urandom));
    reset = 1'b1;
  endtask

  int lat;
  bit seen;
  int f0, i0;
  logic [3:0] rv;

  initial begin
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    compare_all();
    reset = 1'b1;

    // Clean one-hot move after arming; measure latency from first sample.
    repeat (10) cycle(1'b1, 4'b0000);
    check("armed", db_estado, P_ARMED);
    n_feita = 0; n_inval = 0; lat = 0; seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 4'b0001);
      if (!seen) begin
        lat++;
        if (jogada_feita) seen = 1'b1;
      end
    end
    check("latency", lat, D + 3);
    check("feita_once", n_feita, 1);
    check("jogada_0001", jogada, 4'b0001);

    // Short glitch: no move, back to armed, jogada kept.
    repeat (8) cycle(1'b1, 4'b0000);
    f0 = n_feita + n_inval;
    repeat (2) cycle(1'b1, 4'b0010);
    repeat (4) cycle(1'b1, 4'b0000);
    check("glitch_state", db_estado, P_ARMED);
    check("glitch_nopulse", n_feita + n_inval, f0);
    check("glitch_jogada", jogada, 4'b0001);

    // Non-one-hot move.
    f0 = n_feita; i0 = n_inval;
    repeat (8) cycle(1'b1, 4'b0011);
    check("inval_once", n_inval - i0, 1);
    check("inval_nofeita", n_feita - f0, 0);
    check("jogada_0011", jogada, 4'b0011);

    // Idle while armed, then activity, then disable.
    repeat (8) cycle(1'b1, 4'b0000);
    repeat (22) cycle(1'b1, 4'b0000);
    check("to_level", timeout, TO_EN);
    check("to_state", db_estado, TO_EN ? P_EXPIRED : P_ARMED);
    f0 = n_feita;
    repeat (8) cycle(1'b1, 4'b0100);
    check("to_ignore", n_feita - f0, TO_EN ? 0 : 1);
    cycle(1'b0, 4'b0100);
    check("to_clear", timeout, 1'b0);
    check("to_idle", db_estado, P_IDLE);

    // Reset two cycles into the filter.
    repeat (8) cycle(1'b1, 4'b0000);
    repeat (4) cycle(1'b1, 4'b1000);
    check("pre_rst_filter", db_estado, P_FILTER);
    f0 = n_feita + n_inval;
    async_reset(2);
    repeat (3) cycle(1'b0, 4'b1000);
    repeat (5) cycle(1'b1, 4'b1000);
    check("post_rst_nopulse", n_feita + n_inval, f0);

    // Long idle armed window, then a move.
    cycle(1'b0, 4'b0000);
    repeat (100) cycle(1'b1, 4'b0000);
    check("long_idle_to", timeout, TO_EN);
    f0 = n_feita;
    repeat (12) cycle(1'b1, 4'b0001);
    check("long_idle_move", n_feita - f0, TO_EN ? 0 : 1);
    cycle(1'b0, 4'b0000);

    // Random traffic against the model.
    for (int seg = 0; seg < 500; seg++) begin
      int r;
      int n;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        async_reset($urandom_range(0, 3));
      end else if (r < 9) begin
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'($urandom));
      end else begin
        r = $urandom_range(0, 9);
        if (r < 4) rv = 4'b0000;
        else if (r < 7) rv = 4'b0001 << $urandom_range(0, 3);
        else rv = 4'($urandom);
        n = (rv == 0) ? $urandom_range(1, 25) : $urandom_range(1, 10);
        for (int i = 0; i < n; i++) cycle(1'b1, rv);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
